// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the integer-to-float converter and the FP adder/subtractor.
// Holds field widths, exponent constants, canonical zeros and the converter state encoding.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FP_BIAS = 127;

    // Biased exponent of a 32-bit integer whose MSB sits in bit 31.
    localparam logic [EXP_W-1:0] INT_EXP_TOP = EXP_W'(FP_BIAS + 31);

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even on a normalised mantissa with guard and sticky bits.
// A mantissa carry-out renormalises by bumping the exponent and clearing the mantissa.
module fp_rne_round
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic [EXP_W-1:0]  exp,
    input  logic              guard,
    input  logic              sticky,
    output logic [MANT_W-1:0] mant_rnd,
    output logic [EXP_W-1:0]  exp_rnd,
    output logic              inexact
);

    logic              round_up;
    logic [MANT_W:0]   mant_inc;

    assign round_up = guard & (sticky | mant[0]);
    assign mant_inc = {1'b0, mant} + {{MANT_W{1'b0}}, 1'b1};
    assign inexact  = guard | sticky;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        mant_rnd = mant;
        exp_rnd  = exp;
        if (round_up) begin
            mant_rnd = mant_inc[MANT_W-1:0];
            if (mant_inc[MANT_W]) begin
                exp_rnd = exp + EXP_W'(1);
            end
        end
    end

endmodule

// File: rtl/int_to_fp_converter.sv
// Multi-cycle 32-bit integer to FP32 converter: one-bit-per-cycle normalisation, then RNE rounding.
// Valid/ready on both sides with a single conversion in flight.
module int_to_fp_converter
    import fp_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact,
    output logic        out_zero
);

    conv_state_t       state, state_next;
    logic              sign;
    logic [31:0]       mag;
    logic [EXP_W-1:0]  exp;

    logic              sign_in;
    logic [31:0]       mag_in;
    logic [MANT_W-1:0] rnd_mant;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_inexact;

    // Two's-complement negation maps 0x80000000 onto itself, which is the correct magnitude.
    assign sign_in = SIGNED_IN & in_data[31];
    assign mag_in  = sign_in ? (~in_data + 32'd1) : in_data;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    fp_rne_round u_round (
        .mant     (mag[30:8]),
        .exp      (exp),
        .guard    (mag[7]),
        .sticky   (|mag[6:0]),
        .mant_rnd (rnd_mant),
        .exp_rnd  (rnd_exp),
        .inexact  (rnd_inexact)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (mag_in == 32'd0) ? DONE : NORM;
            NORM:    if (mag[31]) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            mag         <= '0;
            exp         <= '0;
            out_data    <= '0;
            out_inexact <= 1'b0;
            out_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= sign_in;
                        mag  <= mag_in;
                        exp  <= INT_EXP_TOP;
                        if (mag_in == 32'd0) begin
                            out_data    <= FP_POS_ZERO;
                            out_inexact <= 1'b0;
                            out_zero    <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= mag << 1;
                        exp <= exp - EXP_W'(1);
                    end
                end
                ROUND: begin
                    out_data    <= {sign, rnd_exp, rnd_mant};
                    out_inexact <= rnd_inexact;
                    out_zero    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Self-checking bench for int_to_fp_converter: a signed and an unsigned instance share stimulus.
// Expected results are queued on drive and compared when out_valid appears.
module tb_int_to_fp_converter;

    typedef struct packed {
        logic [31:0] data;
        logic        inexact;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_inexact, s_out_zero;
    logic [31:0] s_out_data;
    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_inexact, u_out_zero;
    logic [31:0] u_out_data;

    logic        in_ready, out_valid, out_inexact, out_zero;
    logic [31:0] out_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign s_in_valid  = in_valid & ~sel;
    assign u_in_valid  = in_valid & sel;
    assign s_out_ready = out_ready & ~sel;
    assign u_out_ready = out_ready & sel;
    assign in_ready    = sel ? u_in_ready    : s_in_ready;
    assign out_valid   = sel ? u_out_valid   : s_out_valid;
    assign out_data    = sel ? u_out_data    : s_out_data;
    assign out_inexact = sel ? u_out_inexact : s_out_inexact;
    assign out_zero    = sel ? u_out_zero    : s_out_zero;

    int_to_fp_converter #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_inexact(s_out_inexact), .out_zero(s_out_zero)
    );

    int_to_fp_converter #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
        .out_inexact(u_out_inexact), .out_zero(u_out_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge after the accept edge.
    task automatic start(input string tag, input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " out_data"}, out_data, e.data);
            check({tag, " out_inexact"}, 32'(out_inexact), 32'(e.inexact));
            check({tag, " out_zero"}, 32'(out_zero), 32'(e.zero));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " drop out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " back to idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic conv(input string tag, input logic [31:0] d, input logic [31:0] e_data,
                        input logic e_inx, input logic e_zero, input int lat);
        sb.push_back('{data: e_data, inexact: e_inx, zero: e_zero});
        start(tag, d);
        wait_out(tag, lat);
        handshake(tag);
    endtask

    initial begin
        int vcount;
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #12;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        check("reset flags", {30'd0, out_inexact, out_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Signed instance: latency lz+2 for nonzero, 0 further edges for zero.
        conv("s one",       32'd1,          32'h3F80_0000, 1'b0, 1'b0, 33);
        conv("s minus one", 32'hFFFF_FFFF,  32'hBF80_0000, 1'b0, 1'b0, 33);
        conv("s int_min",   32'h8000_0000,  32'hCF00_0000, 1'b0, 1'b0, 2);
        conv("s tie even",  32'd16777217,   32'h4B80_0000, 1'b1, 1'b0, 9);
        conv("s tie odd",   32'd16777219,   32'h4B80_0002, 1'b1, 1'b0, 9);
        conv("s seven",     32'd7,          32'h40E0_0000, 1'b0, 1'b0, 31);
        conv("s int_max",   32'h7FFF_FFFF,  32'h4F00_0000, 1'b1, 1'b0, 3);
        conv("s zero",      32'd0,          32'h0000_0000, 1'b0, 1'b1, 0);

        sel = 1'b1;
        conv("u all ones",  32'hFFFF_FFFF,  32'h4F80_0000, 1'b1, 1'b0, 2);
        conv("u zero",      32'd0,          32'h0000_0000, 1'b0, 1'b1, 0);
        conv("u seven",     32'd7,          32'h40E0_0000, 1'b0, 1'b0, 31);

        // Backpressure: result held while in_valid toggles data; next input waits for IDLE.
        sel = 1'b0;
        sb.push_back('{data: 32'h40E0_0000, inexact: 1'b0, zero: 1'b0});
        start("bp first", 32'd7);
        wait_out("bp first", 31);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
            check("bp hold data", out_data, 32'h40E0_0000);
        end
        in_data = 32'hFFFF_FFF9;
        sb.push_back('{data: 32'hC0E0_0000, inexact: 1'b0, zero: 1'b0});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp single handshake", 32'(out_valid), 32'd0);
        check("bp idle in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("bp second", 31);
        handshake("bp second");

        // Asynchronous reset in the middle of normalisation.
        start("abort", 32'd1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort release in_ready", 32'(in_ready), 32'd1);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("abort no output", 32'(vcount), 32'd0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
